// File: rtl/alu_issue.sv
// alu_issue: issue and writeback stage wrapped around a single-cycle registered ALU.
//
// Accepts decoded instructions over a valid/ready handshake, reads operands from
// the 32-entry architectural register file (with forwarding from WB), stalls on
// an EX-stage dependency, registers opcode/operands into the ALU and writes the
// ALU result back one cycle later.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid / in_ready        instruction handshake (accept when both high)
//   in_opcode, in_rd, in_rs1,
//   in_rs2, in_use_imm, in_imm decoded instruction fields
//   alu_opcode, alu_value1,
//   alu_value2                 registered ALU inputs
//   alu_result                 registered ALU output
//   wb_valid, wb_rd, wb_data   instruction retiring this cycle
//   retire_count               retired instruction count, wraps modulo 2^32

module alu_issue #(
   parameter int DATA_WIDTH = 64,
   parameter int REG_COUNT  = 32,
   localparam int IDX_W     = $clog2(REG_COUNT)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_opcode,
   input  logic [IDX_W-1:0]      in_rd,
   input  logic [IDX_W-1:0]      in_rs1,
   input  logic [IDX_W-1:0]      in_rs2,
   input  logic                  in_use_imm,
   input  logic [DATA_WIDTH-1:0] in_imm,
   output logic [3:0]            alu_opcode,
   output logic [DATA_WIDTH-1:0] alu_value1,
   output logic [DATA_WIDTH-1:0] alu_value2,
   input  logic [DATA_WIDTH-1:0] alu_result,
   output logic                  wb_valid,
   output logic [IDX_W-1:0]      wb_rd,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic [31:0]           retire_count
);

   logic [DATA_WIDTH-1:0] rf [REG_COUNT];

   logic                  ex_valid;
   logic [IDX_W-1:0]      ex_rd;

   logic [DATA_WIDTH-1:0] operand1;
   logic [DATA_WIDTH-1:0] operand2;
   logic                  ex_hazard;
   logic                  accept;

   assign wb_data = alu_result;

   // Source read: x0 is hard zero, then WB forwarding (covers the same-cycle
   // write/read case), then the register file.
   always_comb begin
      operand1 = '0;
      if (in_rs1 == '0)
         operand1 = '0;
      else if (wb_valid && (wb_rd == in_rs1))
         operand1 = alu_result;
      else
         operand1 = rf[in_rs1];
   end

   always_comb begin
      operand2 = '0;
      if (in_rs2 == '0)
         operand2 = '0;
      else if (wb_valid && (wb_rd == in_rs2))
         operand2 = alu_result;
      else
         operand2 = rf[in_rs2];
   end

   // The instruction in EX has no result yet, so a consumer must wait one
   // cycle and then pick the value up through WB forwarding. rs2 only counts
   // when it is actually read.
   always_comb begin
      ex_hazard = 1'b0;
      if (ex_valid && (ex_rd != '0)) begin
         if (ex_rd == in_rs1)
            ex_hazard = 1'b1;
         if (!in_use_imm && (ex_rd == in_rs2))
            ex_hazard = 1'b1;
      end
   end

   assign in_ready = ~ex_hazard;
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid   <= 1'b0;
         ex_rd      <= '0;
         wb_valid   <= 1'b0;
         wb_rd      <= '0;
         alu_opcode <= '0;
         alu_value1 <= '0;
         alu_value2 <= '0;
      end else begin
         ex_valid <= accept;
         if (accept) begin
            ex_rd      <= in_rd;
            alu_opcode <= in_opcode;
            alu_value1 <= operand1;
            alu_value2 <= in_use_imm ? in_imm : operand2;
         end
         wb_valid <= ex_valid;
         wb_rd    <= ex_rd;
      end
   end

   // Writes to x0 are dropped here; wb_valid still reports the retirement.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < REG_COUNT; i++)
            rf[i] <= '0;
      end else if (wb_valid && (wb_rd != '0)) begin
         rf[wb_rd] <= alu_result;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         retire_count <= '0;
      else if (wb_valid)
         retire_count <= retire_count + 32'd1;
   end

endmodule
